// File: rtl/sram_arbiter_pkg.sv
// Shared types for the IF/EX memory bus arbiter.
// Grant states, source encodings and the request bundle.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_HOLD_I = 2'd1,
        ARB_HOLD_D = 2'd2
    } arb_state_t;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/sram_arbiter_src_fifo.sv
// In-order FIFO of 1-bit request sources.
// Pop on empty is ignored; the caller treats it as a stray.
module src_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Fixed-priority arbiter sharing one SRAM-like bus between IF and EX/MEM.
// Data wins ties; an unaccepted grant is held until taken or abandoned.
import sram_arbiter_pkg::*;

module sram_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,

    output logic        err_stray_ok
);

    arb_state_t state_q;
    arb_state_t state_d;

    mem_req_t inst_r;
    mem_req_t data_r;
    mem_req_t gnt_r;

    logic sel_data;
    logic gnt_req;
    logic accept;
    logic pop;
    logic head;
    logic full;
    logic empty;

    assign inst_r = '{inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
    assign data_r = '{data_wr, data_size, data_wstrb, data_addr, data_wdata};

    always_comb begin
        sel_data = 1'b0;
        unique case (state_q)
            ARB_IDLE:   sel_data = data_req;
            ARB_HOLD_I: sel_data = 1'b0;
            ARB_HOLD_D: sel_data = 1'b1;
            default:    sel_data = 1'b0;
        endcase
    end

    assign gnt_r   = sel_data ? data_r : inst_r;
    assign gnt_req = sel_data ? data_req : inst_req;

    // Masking the request when full keeps the FIFO from overflowing.
    assign bus_req   = gnt_req && !full;
    assign bus_wr    = gnt_r.wr;
    assign bus_size  = gnt_r.size;
    assign bus_wstrb = gnt_r.wstrb;
    assign bus_addr  = gnt_r.addr;
    assign bus_wdata = gnt_r.wdata;

    assign accept       = bus_req && bus_addr_ok;
    assign inst_addr_ok = accept && !sel_data;
    assign data_addr_ok = accept && sel_data;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (bus_req && !bus_addr_ok)
                    state_d = sel_data ? ARB_HOLD_D : ARB_HOLD_I;
            end
            ARB_HOLD_I, ARB_HOLD_D: begin
                if (!gnt_req || accept)
                    state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= ARB_IDLE;
        else
            state_q <= state_d;
    end

    src_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .din   (sel_data ? SRC_DATA : SRC_INST),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign pop          = bus_data_ok && !empty;
    assign inst_data_ok = pop && (head == SRC_INST);
    assign data_data_ok = pop && (head == SRC_DATA);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_stray_ok <= 1'b0;
        else if (bus_data_ok && empty)
            err_stray_ok <= 1'b1;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter; responses checked by a scoreboard.
import sram_arbiter_pkg::*;

module tb_sram_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        err_stray_ok;

    typedef struct {
        logic        src;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    sram_arbiter #(.DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_wstrb    (bus_wstrb),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata),
        .err_stray_ok (err_stray_ok)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic resp(input logic src, input logic [31:0] rd);
        exp_t e;
        e.src       = src;
        e.rdata     = rd;
        bus_data_ok = 1'b1;
        bus_rdata   = rd;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] cnt();
        return {28'b0, dut.u_fifo.count};
    endfunction

    // Monitor: every forwarded response must match the head expectation.
    always @(negedge clk) begin
        if (inst_data_ok || data_data_ok) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual=%b%b required=none",
                         inst_data_ok, data_data_ok);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_onehot", {31'b0, inst_data_ok & data_data_ok}, 0);
                chk("resp_src", {31'b0, data_data_ok}, {31'b0, e.src});
                chk("resp_rdata", e.src ? data_rdata : inst_rdata, e.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hf;
        inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hf;
        data_addr = 0; data_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
        #2;
        chk("rst_bus_req", {31'b0, bus_req}, 0);
        chk("rst_addr_ok", {30'b0, inst_addr_ok, data_addr_ok}, 0);
        chk("rst_data_ok", {30'b0, inst_data_ok, data_data_ok}, 0);
        chk("rst_err", {31'b0, err_stray_ok}, 0);
        chk("rst_count", cnt(), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Tie: data wins
        cyc();
        inst_req = 1; inst_addr = 32'h100;
        data_req = 1; data_addr = 32'h200; data_wr = 1; data_wdata = 32'hcafe;
        bus_addr_ok = 1;
        #1;
        chk("tie_data_addr_ok", {31'b0, data_addr_ok}, 1);
        chk("tie_inst_addr_ok", {31'b0, inst_addr_ok}, 0);
        chk("tie_bus_addr", bus_addr, 32'h200);
        chk("tie_bus_wr", {31'b0, bus_wr}, 1);
        cyc();
        inst_req = 0; data_req = 0; data_wr = 0; bus_addr_ok = 0;
        chk("tie_count", cnt(), 1);
        cyc();
        resp(SRC_DATA, 32'h1234_5678);
        #1;
        chk("tie_data_ok", {31'b0, data_data_ok}, 1);
        chk("tie_data_rdata", data_rdata, 32'h1234_5678);
        cyc();
        bus_data_ok = 0;

        // Held grant on inst while data arrives
        cyc();
        inst_req = 1; inst_addr = 32'h300; data_addr = 32'h400;
        #1;
        chk("hold_c1_addr", bus_addr, 32'h300);
        chk("hold_c1_req", {31'b0, bus_req}, 1);
        cyc();
        data_req = 1;
        #1;
        chk("hold_c2_addr", bus_addr, 32'h300);
        chk("hold_c2_aok", {30'b0, inst_addr_ok, data_addr_ok}, 0);
        cyc();
        #1;
        chk("hold_c3_addr", bus_addr, 32'h300);
        cyc();
        bus_addr_ok = 1;
        #1;
        chk("hold_inst_acc", {30'b0, inst_addr_ok, data_addr_ok}, 2);
        chk("hold_acc_addr", bus_addr, 32'h300);
        cyc();
        inst_req = 0;
        #1;
        chk("hold_data_acc", {30'b0, inst_addr_ok, data_addr_ok}, 1);
        chk("hold_data_addr", bus_addr, 32'h400);
        cyc();
        data_req = 0; bus_addr_ok = 0;
        chk("hold_count", cnt(), 2);
        resp(SRC_INST, 32'haaaa_0001);
        cyc();
        resp(SRC_DATA, 32'hbbbb_0002);
        cyc();
        bus_data_ok = 0;
        chk("hold_drained", cnt(), 0);

        // In-order steering: inst, data, inst
        cyc();
        inst_req = 1; bus_addr_ok = 1;
        #1 chk("ord_acc0", {30'b0, inst_addr_ok, data_addr_ok}, 2);
        cyc();
        inst_req = 0; data_req = 1;
        #1 chk("ord_acc1", {30'b0, inst_addr_ok, data_addr_ok}, 1);
        cyc();
        data_req = 0; inst_req = 1;
        #1 chk("ord_acc2", {30'b0, inst_addr_ok, data_addr_ok}, 2);
        cyc();
        inst_req = 0; bus_addr_ok = 0;
        resp(SRC_INST, 32'h0000_0011);
        cyc();
        resp(SRC_DATA, 32'h0000_0022);
        cyc();
        resp(SRC_INST, 32'h0000_0033);
        cyc();
        bus_data_ok = 0;
        chk("ord_empty", cnt(), 0);

        // Fill to DEPTH, then pop / push+pop
        cyc();
        inst_req = 1; data_req = 1; bus_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("full_fill_acc", {30'b0, inst_addr_ok, data_addr_ok}, 1);
            cyc();
        end
        #1;
        chk("full_count", cnt(), 4);
        chk("full_bus_req", {31'b0, bus_req}, 0);
        chk("full_aok", {30'b0, inst_addr_ok, data_addr_ok}, 0);
        chk("full_state", {30'b0, dut.state_q}, {30'b0, ARB_IDLE});
        resp(SRC_DATA, 32'h0000_00c1);
        #1 chk("full_pop_req", {31'b0, bus_req}, 0);
        cyc();
        chk("full_count_pop", cnt(), 3);
        resp(SRC_DATA, 32'h0000_00d2);
        #1;
        chk("full_reopen_req", {31'b0, bus_req}, 1);
        chk("full_reopen_aok", {31'b0, data_addr_ok}, 1);
        cyc();
        chk("full_count_pp", cnt(), 3);
        inst_req = 0; data_req = 0; bus_addr_ok = 0;
        for (int i = 0; i < 3; i++) begin
            resp(SRC_DATA, 32'h0000_0e00 + i);
            cyc();
        end
        bus_data_ok = 0;
        chk("full_drained", cnt(), 0);

        // Stray response
        cyc();
        bus_data_ok = 1; bus_rdata = 32'hdead_beef;
        #1 chk("stray_no_ok", {30'b0, inst_data_ok, data_data_ok}, 0);
        cyc();
        bus_data_ok = 0;
        chk("stray_err", {31'b0, err_stray_ok}, 1);
        chk("stray_count", cnt(), 0);
        repeat (10) cyc();
        chk("stray_sticky", {31'b0, err_stray_ok}, 1);

        // Reset in HOLD_D with two outstanding
        data_req = 1; data_addr = 32'h500; bus_addr_ok = 1;
        cyc();
        cyc();
        bus_addr_ok = 0;
        cyc();
        chk("mid_state", {30'b0, dut.state_q}, {30'b0, ARB_HOLD_D});
        chk("mid_count", cnt(), 2);
        reset = 0; data_req = 0;
        #1;
        chk("mid_rst_state", {30'b0, dut.state_q}, {30'b0, ARB_IDLE});
        chk("mid_rst_count", cnt(), 0);
        chk("mid_rst_bus_req", {31'b0, bus_req}, 0);
        chk("mid_rst_err", {31'b0, err_stray_ok}, 0);
        cyc();
        reset = 1;
        cyc();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
